fifo_1p_ctrl: RTL and testbench

- FIFO controller built around one single-port RAM instance (Word_Width x 2^Addr_Width, active-low cen/oen/wen, 1-cycle registered read).
- Drives every RAM input port and consumes the RAM read data.
- Presents valid/ready streams upstream and downstream.
- Hides the single-port read/write conflict and the read latency with a 2-entry output buffer.
- Used for line/coefficient buffering between encoder pipeline stages.

---
 rtl/fifo_1p_ctrl_if.sv | 23 ++
 rtl/fifo_1p_ctrl.sv | 129 ++++++++++++
 tb/tb_fifo_1p_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_1p_ctrl_if.sv
// rtl/fifo_1p_ctrl_if.sv - upstream/downstream stream bundle for fifo_1p_ctrl
interface fifo_1p_ctrl_if #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [Word_Width-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [Word_Width-1:0] out_data_o;
    logic [Addr_Width+1:0] level_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, level_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, level_o
    );
endinterface

// File: rtl/fifo_1p_ctrl.sv
// rtl/fifo_1p_ctrl.sv - stream FIFO on one single-port RAM with a 2-entry output buffer
module fifo_1p_ctrl #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    fifo_1p_ctrl_if.slave         s,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [Addr_Width-1:0] ram_addr_o,
    output logic [Word_Width-1:0] ram_data_o,
    input  logic [Word_Width-1:0] ram_data_i
);
    localparam logic [Addr_Width:0] DEPTH = (Addr_Width+1)'(1) << Addr_Width;

    logic [Addr_Width-1:0] wr_ptr_q, wr_ptr_d;
    logic [Addr_Width-1:0] rd_ptr_q, rd_ptr_d;
    logic [Addr_Width:0]   ram_cnt_q, ram_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  last_wr_q, last_wr_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;
    logic [Word_Width-1:0] obuf0_q, obuf0_d;
    logic [Word_Width-1:0] obuf1_q, obuf1_d;

    logic rd_sel, in_ready, wr_do, rd_do, capture, pop;

    // Reads only when the buffer has a free slot counting the in-flight word;
    // once the buffer holds data, a read must follow a write so writes are never starved.
    always_comb begin
        rd_sel   = (ram_cnt_q != '0)
                && ((obuf_cnt_q + {1'b0, rd_pend_q}) < 2'd2)
                && ((obuf_cnt_q == 2'd0) || last_wr_q);
        in_ready = !clr_i && !rd_sel && (ram_cnt_q != DEPTH);
        wr_do    = s.in_valid_i && in_ready;
        rd_do    = rd_sel && !clr_i;
        capture  = rd_pend_q && !clr_i;
        pop      = (obuf_cnt_q != 2'd0) && s.out_ready_i;
    end

    assign s.in_ready_o  = in_ready;
    assign s.out_valid_o = (obuf_cnt_q != 2'd0);
    assign s.out_data_o  = obuf0_q;
    assign s.level_o     = (Addr_Width+2)'(ram_cnt_q) + (Addr_Width+2)'(rd_pend_q)
                         + (Addr_Width+2)'(obuf_cnt_q);

    assign ram_cen_o  = !(wr_do || rd_do);
    assign ram_wen_o  = !wr_do;
    assign ram_oen_o  = 1'b0;
    assign ram_addr_o = rd_sel ? rd_ptr_q : wr_ptr_q;
    assign ram_data_o = s.in_data_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        rd_pend_d  = 1'b0;
        last_wr_d  = last_wr_q;
        obuf_cnt_d = obuf_cnt_q;
        obuf0_d    = obuf0_q;
        obuf1_d    = obuf1_q;

        if (wr_do) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q + 1'b1;
            last_wr_d = 1'b1;
        end else if (rd_do) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q - 1'b1;
            rd_pend_d = 1'b1;
            last_wr_d = 1'b0;
        end

        // Head always lives in obuf0 so out_data_o is a plain register.
        case ({capture, pop})
            2'b10: begin
                if (obuf_cnt_q == 2'd0) obuf0_d = ram_data_i;
                else                    obuf1_d = ram_data_i;
                obuf_cnt_d = obuf_cnt_q + 2'd1;
            end
            2'b01: begin
                obuf0_d    = obuf1_q;
                obuf_cnt_d = obuf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (obuf_cnt_q == 2'd1) begin
                    obuf0_d = ram_data_i;
                end else begin
                    obuf0_d = obuf1_q;
                    obuf1_d = ram_data_i;
                end
            end
            default: ;
        endcase

        if (clr_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            rd_pend_d  = 1'b0;
            last_wr_d  = 1'b1;
            obuf_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            last_wr_q  <= 1'b1;
            obuf_cnt_q <= 2'd0;
            obuf0_q    <= '0;
            obuf1_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            rd_pend_q  <= rd_pend_d;
            last_wr_q  <= last_wr_d;
            obuf_cnt_q <= obuf_cnt_d;
            obuf0_q    <= obuf0_d;
            obuf1_q    <= obuf1_d;
        end
    end
endmodule

// File: tb/tb_fifo_1p_ctrl.sv
// tb/tb_fifo_1p_ctrl.sv - self-checking bench for fifo_1p_ctrl with RAM model and scoreboard
module tb_fifo_1p_ctrl;
    localparam int WW = 32;
    localparam int AW = 3;
    localparam int MAXLVL = (1 << AW) + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_i = 1'b0;
    logic          ram_cen_o, ram_oen_o, ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [WW-1:0] ram_data_o, ram_data_i;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    logic [WW-1:0] sb[$];
    logic [WW-1:0] mem[1 << AW];

    always #5 clk = ~clk;

    fifo_1p_ctrl_if #(.Word_Width(WW), .Addr_Width(AW)) bus();

    fifo_1p_ctrl #(.Word_Width(WW), .Addr_Width(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_i),
        .s          (bus),
        .ram_cen_o  (ram_cen_o),
        .ram_oen_o  (ram_oen_o),
        .ram_wen_o  (ram_wen_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    // Single-port RAM: registered read, data X in every cycle that is not a read-data cycle.
    always @(posedge clk) begin
        if (!ram_cen_o && ram_wen_o && !ram_oen_o) ram_data_i <= mem[ram_addr_o];
        else                                       ram_data_i <= 'x;
        if (!ram_cen_o && !ram_wen_o) mem[ram_addr_o] <= ram_data_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: FIFO order, level = accepted - popped, RAM protocol rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (mon_en) begin
            if (clr_i) chk("cen_on_clr", 64'(ram_cen_o), 64'd1);
            chk("level", 64'(bus.level_o), 64'(sb.size()));
            if (bus.level_o >= (AW+2)'(MAXLVL)) chk("full_blocks", 64'(bus.in_ready_o), 64'd0);
            if (bus.out_valid_o) chk("out_known", 64'($isunknown(bus.out_data_o)), 64'd0);
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL pop_empty observed=%0h expected=none", bus.out_data_o);
                end else begin
                    chk("order", 64'(bus.out_data_o), 64'(sb.pop_front()));
                end
            end
            if (bus.in_valid_i && bus.in_ready_o) sb.push_back(bus.in_data_i);
            if (clr_i) sb.delete();
        end
    end

    // Push one word into an empty FIFO and check write/read/emerge timing.
    task automatic push_lat(input string tag, input logic [WW-1:0] w);
        tick();
        bus.in_valid_i = 1'b1; bus.in_data_i = w; bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk({tag, "_wr_cen"}, 64'(ram_cen_o), 64'd0);
        chk({tag, "_wr_wen"}, 64'(ram_wen_o), 64'd0);
        chk({tag, "_wr_addr"}, 64'(ram_addr_o), 64'd0);
        chk({tag, "_wr_data"}, 64'(ram_data_o), 64'(w));
        tick();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_rd_cen"}, 64'(ram_cen_o), 64'd0);
        chk({tag, "_rd_wen"}, 64'(ram_wen_o), 64'd1);
        chk({tag, "_rd_addr"}, 64'(ram_addr_o), 64'd0);
        tick();
        @(negedge clk);
        chk({tag, "_c2_valid"}, 64'(bus.out_valid_o), 64'd0);
        tick();
        @(negedge clk);
        chk({tag, "_c3_valid"}, 64'(bus.out_valid_o), 64'd1);
        chk({tag, "_c3_data"}, 64'(bus.out_data_o), 64'(w));
        tick();
        @(negedge clk);
        chk({tag, "_level0"}, 64'(bus.level_o), 64'd0);
        chk({tag, "_empty"}, 64'(bus.out_valid_o), 64'd0);
    endtask

    initial begin
        int nxt, acc, budget;
        bit found;
        bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b0;

        // Reset values
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_level", 64'(bus.level_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_cen", 64'(ram_cen_o), 64'd1);
        chk("rst_wen", 64'(ram_wen_o), 64'd1);
        chk("rst_oen", 64'(ram_oen_o), 64'd0);
        chk("rst_addr", 64'(ram_addr_o), 64'd0);
        mon_en = 1'b1;

        // Single word latency
        push_lat("t1", 32'hA5A5_A5A5);

        // Fill to full with the sink stalled, then drain
        nxt = 0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            bus.in_valid_i = (nxt < 16); bus.in_data_i = WW'(nxt);
            @(negedge clk);
            if (bus.in_valid_i && bus.in_ready_o) nxt++;
        end
        chk("t2_accepted", 64'(nxt), 64'd10);
        chk("t2_level", 64'(bus.level_o), 64'd10);
        chk("t2_in_ready", 64'(bus.in_ready_o), 64'd0);
        budget = 0;
        while (nxt < 16 && budget < 200) begin
            tick();
            bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = WW'(nxt);
            @(negedge clk);
            if (bus.in_ready_o) nxt++;
            budget++;
        end
        tick();
        bus.in_valid_i = 1'b0;
        budget = 0;
        while (bus.level_o != 0 && budget < 200) begin tick(); budget++; end
        chk("t2_drained", 64'(bus.level_o), 64'd0);

        // Continuous streaming
        acc = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1; bus.in_data_i = WW'(32'h100 + i);
            @(negedge clk);
            if (bus.in_ready_o) acc++;
        end
        chk("t3_rate_ok", 64'(acc >= 30 && acc <= 33), 64'd1);

        // Flush with a read in flight at level 5
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            bus.in_valid_i = (bus.level_o < 5) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.in_data_i = $urandom;
            bus.out_ready_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (!ram_cen_o && ram_wen_o && bus.level_o == 5 && !(bus.out_valid_o && bus.out_ready_i))
                found = 1'b1;
        end
        chk("t4_found", 64'(found), 64'd1);
        tick();
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0; clr_i = 1'b1;
        @(negedge clk);
        chk("t4_clr_level", 64'(bus.level_o), 64'd5);
        tick();
        clr_i = 1'b0;
        @(negedge clk);
        chk("t4_level", 64'(bus.level_o), 64'd0);
        chk("t4_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t4_in_ready", 64'(bus.in_ready_o), 64'd1);
        push_lat("t4", 32'h1234_5678);

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            tick();
            bus.in_valid_i = 1'($urandom_range(0, 1));
            bus.in_data_i = $urandom;
            bus.out_ready_i = ((i / 1000) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr_i = ($urandom_range(0, 127) == 0);
        end
        tick();
        clr_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        budget = 0;
        while (bus.level_o != 0 && budget < 200) begin tick(); budget++; end
        chk("t5_drained", 64'(bus.level_o), 64'd0);

        // Asynchronous reset mid-burst at level 7
        bus.out_ready_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (bus.level_o == 7) found = 1'b1;
            else begin bus.in_valid_i = 1'b1; bus.in_data_i = $urandom; end
        end
        chk("t6_level7", 64'(found), 64'd1);
        bus.in_valid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t6_cen", 64'(ram_cen_o), 64'd1);
        chk("t6_level", 64'(bus.level_o), 64'd0);
        tick();
        rst_n = 1'b1;
        push_lat("t6", 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
